// File: rtl/ddr3_ui_responder_if.sv
// ddr3_ui_responder_if
//   Bundles the MIG-style application (app_*) interface between the
//   accelerator's DDR3 master and the UI responder.
//   master modport : drives command, write-data, and write-control signals;
//                    receives the ready and read-data signals.
//   slave modport  : the mirror image; used by ddr3_ui_responder.
//   Signals:
//     app_addr / app_cmd / app_en / app_rdy            command channel
//     app_wdf_data / _mask / _wren / _end / _rdy       write-data channel
//     app_rd_data / app_rd_data_valid / _end           read-data channel
interface ddr3_ui_responder_if #(
  parameter int UI_WIDTH   = 512,
  parameter int ADDR_WIDTH = 29
);
  logic [ADDR_WIDTH-1:0]  app_addr;
  logic [2:0]             app_cmd;
  logic                   app_en;
  logic                   app_rdy;
  logic [UI_WIDTH-1:0]    app_wdf_data;
  logic [UI_WIDTH/8-1:0]  app_wdf_mask;
  logic                   app_wdf_wren;
  logic                   app_wdf_end;
  logic                   app_wdf_rdy;
  logic [UI_WIDTH-1:0]    app_rd_data;
  logic                   app_rd_data_valid;
  logic                   app_rd_data_end;

  modport master (
    output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask,
           app_wdf_wren, app_wdf_end,
    input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid,
           app_rd_data_end
  );

  modport slave (
    input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask,
           app_wdf_wren, app_wdf_end,
    output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid,
           app_rd_data_end
  );
endinterface

// File: rtl/ddr3_ui_responder.sv
// ddr3_ui_responder
//   Synthesizable stand-in for the MIG user-interface slave. It accepts
//   commands and write data on the app interface, executes them in order
//   against an on-chip word array, and returns read data after a fixed
//   latency.
//   Ports:
//     ui_clk              UI clock
//     rst_n               asynchronous active-low reset
//     app                 app_* interface (slave modport)
//     init_calib_complete goes high CALIB_CYCLES cycles after reset release
//     err_flag            sticky: illegal command or write beat without end
module ddr3_ui_responder #(
  parameter int UI_WIDTH     = 512,
  parameter int ADDR_WIDTH   = 29,
  parameter int MEM_AW       = 10,
  parameter int CMD_DEPTH    = 4,
  parameter int WDF_DEPTH    = 4,
  parameter int RD_LATENCY   = 4,
  parameter int CALIB_CYCLES = 64,
  parameter int STALL_PERIOD = 0
) (
  input  logic                ui_clk,
  input  logic                rst_n,
  ddr3_ui_responder_if.slave  app,
  output logic                init_calib_complete,
  output logic                err_flag
);

  localparam int BYTES = UI_WIDTH / 8;
  localparam int DEPTH = 1 << MEM_AW;
  localparam int CAW   = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int CCW   = $clog2(CMD_DEPTH + 1);
  localparam int WAW   = (WDF_DEPTH > 1) ? $clog2(WDF_DEPTH) : 1;
  localparam int WCW   = $clog2(WDF_DEPTH + 1);
  localparam int CALW  = (CALIB_CYCLES > 0) ? $clog2(CALIB_CYCLES + 1) : 1;
  localparam int STW   = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;

  localparam logic [CCW-1:0]  CMD_FULL   = CCW'(CMD_DEPTH);
  localparam logic [WCW-1:0]  WDF_FULL   = WCW'(WDF_DEPTH);
  localparam logic [CAW-1:0]  CMD_LAST   = CAW'(CMD_DEPTH - 1);
  localparam logic [WAW-1:0]  WDF_LAST   = WAW'(WDF_DEPTH - 1);
  localparam logic [CALW-1:0] CAL_LAST   = CALW'((CALIB_CYCLES > 0) ? CALIB_CYCLES - 1 : 0);
  localparam logic [STW-1:0]  STALL_LAST = STW'((STALL_PERIOD > 0) ? STALL_PERIOD - 1 : 0);

  // Calibration, stall and error state
  logic            calib_q;
  logic [CALW-1:0] calCnt_q;
  logic [STW-1:0]  stallCnt_q;
  logic            err_q;
  logic            stallCycle;

  // Command queue (op bit is 1 for read)
  logic              cmdRead_q [CMD_DEPTH];
  logic [MEM_AW-1:0] cmdIdx_q  [CMD_DEPTH];
  logic [CAW-1:0]    cmdWr_q, cmdWr_d, cmdRd_q, cmdRd_d;
  logic [CCW-1:0]    cmdCnt_q, cmdCnt_d;

  // Write-data queue
  logic [UI_WIDTH-1:0] wdfData_q [WDF_DEPTH];
  logic [BYTES-1:0]    wdfMask_q [WDF_DEPTH];
  logic [WAW-1:0]      wdfWr_q, wdfWr_d, wdfRd_q, wdfRd_d;
  logic [WCW-1:0]      wdfCnt_q, wdfCnt_d;

  // Backing array and read return pipeline
  logic [UI_WIDTH-1:0]   mem_q      [DEPTH];
  logic [RD_LATENCY-1:0] pipeValid_q;
  logic [UI_WIDTH-1:0]   pipeData_q [RD_LATENCY];

  logic              cmdRdy, wdfRdy, cmdAccept, cmdLegal, cmdPush, wdfPush;
  logic              headRead, execRead, execWrite;
  logic [MEM_AW-1:0] headIdx, pushIdx;
  logic              unusedAddrBits;

  assign pushIdx        = app.app_addr[MEM_AW+2:3];
  assign unusedAddrBits = ^{app.app_addr[ADDR_WIDTH-1:MEM_AW+3], app.app_addr[2:0]};

  // The stall pulse only exists once calibrated and when a period is set.
  assign stallCycle = (STALL_PERIOD != 0) && calib_q && (stallCnt_q == STALL_LAST);

  // Ready flags come from registered state only, so a same-cycle pop
  // never frees a slot for the command being offered.
  assign cmdRdy    = calib_q && (cmdCnt_q < CMD_FULL) && !stallCycle;
  assign wdfRdy    = calib_q && (wdfCnt_q < WDF_FULL);
  assign cmdAccept = app.app_en && cmdRdy;
  assign cmdLegal  = (app.app_cmd == 3'b000) || (app.app_cmd == 3'b001);
  assign cmdPush   = cmdAccept && cmdLegal;
  assign wdfPush   = app.app_wdf_wren && wdfRdy;

  // In-order execution: a write at the head waits for its data and blocks
  // everything behind it, reads included.
  assign headRead  = cmdRead_q[cmdRd_q];
  assign headIdx   = cmdIdx_q[cmdRd_q];
  assign execRead  = (cmdCnt_q != '0) && headRead;
  assign execWrite = (cmdCnt_q != '0) && !headRead && (wdfCnt_q != '0);

  assign app.app_rdy           = cmdRdy;
  assign app.app_wdf_rdy       = wdfRdy;
  assign app.app_rd_data       = pipeData_q[RD_LATENCY-1];
  assign app.app_rd_data_valid = pipeValid_q[RD_LATENCY-1];
  assign app.app_rd_data_end   = pipeValid_q[RD_LATENCY-1];
  assign init_calib_complete   = calib_q;
  assign err_flag              = err_q;

  // Next-state for queue pointers and occupancy counts
  always_comb begin
    cmdWr_d  = cmdWr_q;
    cmdRd_d  = cmdRd_q;
    wdfWr_d  = wdfWr_q;
    wdfRd_d  = wdfRd_q;
    cmdCnt_d = cmdCnt_q + CCW'(cmdPush) - CCW'(execRead || execWrite);
    wdfCnt_d = wdfCnt_q + WCW'(wdfPush) - WCW'(execWrite);
    if (cmdPush)              cmdWr_d = (cmdWr_q == CMD_LAST) ? '0 : cmdWr_q + 1'b1;
    if (execRead || execWrite) cmdRd_d = (cmdRd_q == CMD_LAST) ? '0 : cmdRd_q + 1'b1;
    if (wdfPush)              wdfWr_d = (wdfWr_q == WDF_LAST) ? '0 : wdfWr_q + 1'b1;
    if (execWrite)            wdfRd_d = (wdfRd_q == WDF_LAST) ? '0 : wdfRd_q + 1'b1;
  end

  // Control registers; reset flushes both queues and restarts calibration
  always_ff @(posedge ui_clk or negedge rst_n) begin
    if (!rst_n) begin
      calib_q    <= 1'b0;
      calCnt_q   <= '0;
      stallCnt_q <= '0;
      err_q      <= 1'b0;
      cmdWr_q    <= '0;
      cmdRd_q    <= '0;
      cmdCnt_q   <= '0;
      wdfWr_q    <= '0;
      wdfRd_q    <= '0;
      wdfCnt_q   <= '0;
    end else begin
      if (!calib_q) begin
        calCnt_q <= calCnt_q + 1'b1;
        calib_q  <= (calCnt_q == CAL_LAST);
      end else begin
        stallCnt_q <= (stallCnt_q == STALL_LAST) ? '0 : stallCnt_q + 1'b1;
      end
      if ((cmdAccept && !cmdLegal) || (wdfPush && !app.app_wdf_end)) begin
        err_q <= 1'b1;
      end
      cmdWr_q  <= cmdWr_d;
      cmdRd_q  <= cmdRd_d;
      cmdCnt_q <= cmdCnt_d;
      wdfWr_q  <= wdfWr_d;
      wdfRd_q  <= wdfRd_d;
      wdfCnt_q <= wdfCnt_d;
    end
  end

  // Queue storage needs no reset; occupancy counts decide what is valid
  always_ff @(posedge ui_clk) begin
    if (cmdPush) begin
      cmdRead_q[cmdWr_q] <= app.app_cmd[0];
      cmdIdx_q[cmdWr_q]  <= pushIdx;
    end
    if (wdfPush) begin
      wdfData_q[wdfWr_q] <= app.app_wdf_data;
      wdfMask_q[wdfWr_q] <= app.app_wdf_mask;
    end
  end

  // Backing array keeps its contents across reset; masked bytes are kept
  always_ff @(posedge ui_clk) begin
    if (execWrite) begin
      for (int b = 0; b < BYTES; b++) begin
        if (!wdfMask_q[wdfRd_q][b]) begin
          mem_q[headIdx][8*b +: 8] <= wdfData_q[wdfRd_q][8*b +: 8];
        end
      end
    end
  end

  // Read return pipeline: stage 0 captures the array on the execute cycle,
  // the last stage drives the read-data outputs RD_LATENCY cycles later.
  always_ff @(posedge ui_clk or negedge rst_n) begin
    if (!rst_n) begin
      pipeValid_q <= '0;
      for (int i = 0; i < RD_LATENCY; i++) pipeData_q[i] <= '0;
    end else begin
      for (int i = RD_LATENCY - 1; i > 0; i--) begin
        pipeValid_q[i] <= pipeValid_q[i-1];
        pipeData_q[i]  <= pipeData_q[i-1];
      end
      pipeValid_q[0] <= execRead;
      pipeData_q[0]  <= execRead ? mem_q[headIdx] : '0;
    end
  end

endmodule

// File: tb/tb_ddr3_ui_responder.sv
// tb_ddr3_ui_responder
//   Directed bench for ddr3_ui_responder. A queue-based reference model of
//   the UI slave predicts read data, calibration and error state; a
//   per-cycle compare process checks the DUT against it, and directed
//   literal expectations pin the model.
module tb_ddr3_ui_responder;

  localparam int UIW    = 512;
  localparam int AW     = 29;
  localparam int MEM_AW = 10;
  localparam int CALIB  = 64;
  localparam int RDLAT  = 4;

  logic ui_clk = 1'b0;
  logic rst_n  = 1'b0;
  logic initCalib, errFlag;

  ddr3_ui_responder_if #(.UI_WIDTH(UIW), .ADDR_WIDTH(AW)) appIf ();

  ddr3_ui_responder #(
    .UI_WIDTH(UIW), .ADDR_WIDTH(AW), .MEM_AW(MEM_AW), .CMD_DEPTH(4),
    .WDF_DEPTH(4), .RD_LATENCY(RDLAT), .CALIB_CYCLES(CALIB), .STALL_PERIOD(0)
  ) dut (
    .ui_clk(ui_clk),
    .rst_n(rst_n),
    .app(appIf),
    .init_calib_complete(initCalib),
    .err_flag(errFlag)
  );

  always #5 ui_clk = ~ui_clk;

  int checks   = 0;
  int failures = 0;

  // Single comparison point for every check in the bench
  task automatic checkOutput(input string name, input logic [UIW-1:0] actual,
                             input logic [UIW-1:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, actual, required);
    end
  endtask

  // Reference model: commands and data held as plain queues, array as a
  // sparse word map, expected read returns in command order.
  typedef struct {
    bit isRead;
    int idx;
  } cmd_t;

  cmd_t            mdlCmdQ[$];
  logic [UIW-1:0]  mdlWdfData[$];
  logic [63:0]     mdlWdfMask[$];
  logic [UIW-1:0]  mdlExpRd[$];
  logic [UIW-1:0]  mdlMem[int];
  bit              mdlErr = 1'b0;
  int              calEdges = 0;

  // Retire every command whose prerequisites are met, in command order
  task automatic mdlResolve();
    logic [UIW-1:0] w;
    logic [UIW-1:0] d;
    logic [63:0]    m;
    while (mdlCmdQ.size() > 0) begin
      if (mdlCmdQ[0].isRead) begin
        mdlExpRd.push_back(mdlMem.exists(mdlCmdQ[0].idx) ? mdlMem[mdlCmdQ[0].idx] : 'x);
        void'(mdlCmdQ.pop_front());
      end else if (mdlWdfData.size() > 0) begin
        d = mdlWdfData.pop_front();
        m = mdlWdfMask.pop_front();
        w = mdlMem.exists(mdlCmdQ[0].idx) ? mdlMem[mdlCmdQ[0].idx] : 'x;
        for (int b = 0; b < 64; b++) if (!m[b]) w[8*b +: 8] = d[8*b +: 8];
        mdlMem[mdlCmdQ[0].idx] = w;
        void'(mdlCmdQ.pop_front());
      end else begin
        break;
      end
    end
  endtask

  // Count clock edges seen with reset released
  always @(posedge ui_clk) begin
    if (!rst_n) calEdges = 0;
    else        calEdges++;
  end

  // Per-cycle compare against the model, then feed this cycle's handshakes
  always @(negedge ui_clk) begin
    bit expCal;
    if (!rst_n) begin
      mdlCmdQ.delete();
      mdlWdfData.delete();
      mdlWdfMask.delete();
      mdlExpRd.delete();
      mdlErr = 1'b0;
    end
    expCal = rst_n && (calEdges >= CALIB);
    checkOutput("calib", initCalib, expCal);
    if (!expCal) begin
      checkOutput("rdy_precal", appIf.app_rdy, 0);
      checkOutput("wdf_rdy_precal", appIf.app_wdf_rdy, 0);
    end
    checkOutput("err_flag", errFlag, mdlErr);
    if (appIf.app_rd_data_valid) begin
      checkOutput("rd_end", appIf.app_rd_data_end, 1);
      if (mdlExpRd.size() == 0) checkOutput("rd_unexpected", appIf.app_rd_data_valid, 0);
      else                      checkOutput("rd_data", appIf.app_rd_data, mdlExpRd.pop_front());
    end else begin
      checkOutput("rd_end_idle", appIf.app_rd_data_end, 0);
    end
    if (rst_n) begin
      if (appIf.app_en && appIf.app_rdy) begin
        if (appIf.app_cmd == 3'b000 || appIf.app_cmd == 3'b001)
          mdlCmdQ.push_back('{isRead: appIf.app_cmd[0], idx: int'((appIf.app_addr >> 3) % (1 << MEM_AW))});
        else
          mdlErr = 1'b1;
      end
      if (appIf.app_wdf_wren && appIf.app_wdf_rdy) begin
        mdlWdfData.push_back(appIf.app_wdf_data);
        mdlWdfMask.push_back(appIf.app_wdf_mask);
        if (!appIf.app_wdf_end) mdlErr = 1'b1;
      end
      mdlResolve();
    end
  end

  // Offer one command and hold it until accepted (bounded)
  task automatic applyStimulus(input logic [2:0] cmd, input logic [AW-1:0] addr);
    bit done = 1'b0;
    appIf.app_cmd  = cmd;
    appIf.app_addr = addr;
    appIf.app_en   = 1'b1;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge ui_clk);
      if (appIf.app_rdy) done = 1'b1;
      @(posedge ui_clk);
      #1;
    end
    appIf.app_en = 1'b0;
    if (!done) begin
      checks++;
      failures++;
      $display("[TB] FAIL cmd_accept: got no app_rdy in 100 cycles, required acceptance");
    end
  endtask

  // Offer one write-data beat and hold it until accepted (bounded)
  task automatic sendWdf(input logic [UIW-1:0] data, input logic [63:0] mask, input bit last);
    bit done = 1'b0;
    appIf.app_wdf_data = data;
    appIf.app_wdf_mask = mask;
    appIf.app_wdf_end  = last;
    appIf.app_wdf_wren = 1'b1;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge ui_clk);
      if (appIf.app_wdf_rdy) done = 1'b1;
      @(posedge ui_clk);
      #1;
    end
    appIf.app_wdf_wren = 1'b0;
    appIf.app_wdf_end  = 1'b0;
    if (!done) begin
      checks++;
      failures++;
      $display("[TB] FAIL wdf_accept: got no app_wdf_rdy in 100 cycles, required acceptance");
    end
  endtask

  // Wait for the next read return, counting cycles from the call
  task automatic waitRead(output logic [UIW-1:0] data, output int cyc);
    bit seen = 1'b0;
    data = '0;
    cyc  = 0;
    for (int n = 0; n < 60 && !seen; n++) begin
      @(negedge ui_clk);
      cyc++;
      if (appIf.app_rd_data_valid) begin
        data = appIf.app_rd_data;
        seen = 1'b1;
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("[TB] FAIL rd_wait: got no app_rd_data_valid in 60 cycles, required a read return");
    end
    @(posedge ui_clk);
    #1;
  endtask

  // Hard stop in case a directed step never completes
  initial begin
    #2_000_000;
    failures++;
    $display("[TB] FAIL watchdog: got no end of test, required completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Directed scenario sequence
  initial begin
    logic [UIW-1:0] beef, fives, sevens, rd;
    logic [UIW-1:0] pats [4];
    int             cyc;
    bit             sawValid;

    beef   = {16{32'hDEADBEEF}};
    fives  = {64{8'h55}};
    sevens = {64{8'h77}};
    for (int i = 0; i < 4; i++) pats[i] = {16{32'hC0DE_0000 | i}};

    appIf.app_addr     = '0;
    appIf.app_cmd      = '0;
    appIf.app_en       = 1'b0;
    appIf.app_wdf_data = '0;
    appIf.app_wdf_mask = '0;
    appIf.app_wdf_wren = 1'b0;
    appIf.app_wdf_end  = 1'b0;

    $display("[TB] reset and calibration");
    repeat (3) @(posedge ui_clk);
    #1 rst_n = 1'b1;
    for (int k = 1; k <= 64; k++) begin
      @(posedge ui_clk);
      @(negedge ui_clk);
      if (k == 63) begin
        checkOutput("calib_at_63", initCalib, 0);
        checkOutput("rdy_at_63", appIf.app_rdy, 0);
        checkOutput("wdf_rdy_at_63", appIf.app_wdf_rdy, 0);
      end
      if (k == 64) begin
        checkOutput("calib_at_64", initCalib, 1);
        checkOutput("rdy_at_64", appIf.app_rdy, 1);
        checkOutput("wdf_rdy_at_64", appIf.app_wdf_rdy, 1);
      end
    end
    @(posedge ui_clk);
    #1;

    $display("[TB] full write then read, latency");
    fork
      applyStimulus(3'b000, 29'h40);
      sendWdf(beef, 64'h0, 1'b1);
    join
    applyStimulus(3'b001, 29'h40);
    waitRead(rd, cyc);
    checkOutput("beef_data", rd, beef);
    // one cycle to reach the queue head, then RD_LATENCY cycles
    checkOutput("beef_latency", cyc, 5);

    $display("[TB] masked write");
    fork
      applyStimulus(3'b000, 29'h80);
      sendWdf('0, 64'h0, 1'b1);
    join
    fork
      applyStimulus(3'b000, 29'h80);
      sendWdf({64{8'hAA}}, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
    join
    applyStimulus(3'b001, 29'h80);
    waitRead(rd, cyc);
    checkOutput("masked_byte0", rd[7:0], 8'hAA);
    checkOutput("masked_rest", rd[UIW-1:8], 0);

    $display("[TB] data after command, read queued behind");
    applyStimulus(3'b000, 29'h100);
    applyStimulus(3'b001, 29'h100);
    for (int i = 0; i < 3; i++) begin
      @(negedge ui_clk);
      checkOutput("no_early_read", appIf.app_rd_data_valid, 0);
    end
    @(posedge ui_clk);
    #1;
    sendWdf(fives, 64'h0, 1'b1);
    waitRead(rd, cyc);
    checkOutput("late_data", rd, fives);

    $display("[TB] command queue full");
    for (int i = 0; i < 4; i++) applyStimulus(3'b000, 29'h200 + 29'(i * 8));
    @(negedge ui_clk);
    checkOutput("rdy_full", appIf.app_rdy, 0);
    checkOutput("wdf_rdy_free", appIf.app_wdf_rdy, 1);
    @(posedge ui_clk);
    #1;
    sendWdf(pats[0], 64'h0, 1'b1);
    @(posedge ui_clk);
    @(negedge ui_clk);
    checkOutput("rdy_back", appIf.app_rdy, 1);
    @(posedge ui_clk);
    #1;
    applyStimulus(3'b001, 29'h200);
    for (int i = 1; i < 4; i++) sendWdf(pats[i], 64'h0, 1'b1);
    waitRead(rd, cyc);
    checkOutput("full_readback", rd, pats[0]);

    $display("[TB] error flag");
    applyStimulus(3'b010, 29'h0);
    @(negedge ui_clk);
    checkOutput("err_badcmd", errFlag, 1);
    @(posedge ui_clk);
    #1;
    fork
      applyStimulus(3'b000, 29'h300);
      sendWdf(sevens, 64'h0, 1'b0);
    join
    @(negedge ui_clk);
    checkOutput("err_sticky", errFlag, 1);
    @(posedge ui_clk);
    #1;

    $display("[TB] reset mid-burst");
    applyStimulus(3'b001, 29'h40);
    applyStimulus(3'b001, 29'h80);
    sawValid = 1'b0;
    for (int n = 0; n < 20 && !sawValid; n++) begin
      @(negedge ui_clk);
      if (appIf.app_rd_data_valid) sawValid = 1'b1;
    end
    checkOutput("first_burst_seen", sawValid, 1);
    @(posedge ui_clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rd_valid_reset", appIf.app_rd_data_valid, 0);
    checkOutput("err_reset", errFlag, 0);
    checkOutput("calib_reset", initCalib, 0);
    checkOutput("rdy_reset", appIf.app_rdy, 0);
    repeat (3) @(posedge ui_clk);
    #1 rst_n = 1'b1;
    for (int n = 0; n < 100 && !initCalib; n++) @(negedge ui_clk);
    @(posedge ui_clk);
    #1;
    checkOutput("recal", initCalib, 1);
    applyStimulus(3'b001, 29'h40);
    waitRead(rd, cyc);
    checkOutput("beef_after_reset", rd, beef);

    repeat (10) @(posedge ui_clk);
    checkOutput("rd_drained", mdlExpRd.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ddr3_ui_responder.md
Name: ddr3_ui_responder

Overview:
- Synthesizable stand-in for the MIG user-interface (UI) slave. It answers the app_* command, write-data and read-data channels that the accelerator's DDR3 master drives.
- Backed by an on-chip word array. Accelerator DDR traffic can be simulated and checked without the MIG/PHY and DDR3 device models.
- Sits on the UI clock domain, at the other end of the app interface from the accelerator's memory master.

Parameters:
- UI_WIDTH, 512, app data width in bits (one BL8 burst of a 64-bit DDR).
- ADDR_WIDTH, 29, app_addr width.
- MEM_AW, 10, log2 of backing-array depth in UI words.
- CMD_DEPTH, 4, command queue entries (power of 2).
- WDF_DEPTH, 4, write-data queue entries (power of 2).
- RD_LATENCY, 4, cycles from read execution to app_rd_data_valid (at least 1).
- CALIB_CYCLES, 64, cycles after reset release before init_calib_complete rises.
- STALL_PERIOD, 0, app_rdy is forced low one cycle in every STALL_PERIOD cycles; 0 disables this.

Ports:
- ui_clk  in  1  UI clock.
- rst_n  in  1  asynchronous active-low reset.
- app_addr  in  ADDR_WIDTH  byte-lane column address.
- app_cmd  in  3  command: 3'b000 write, 3'b001 read.
- app_en  in  1  command valid.
- app_rdy  out  1  command accept.
- app_wdf_data  in  UI_WIDTH  write data.
- app_wdf_mask  in  UI_WIDTH/8  byte mask; 1 means the byte is not written.
- app_wdf_wren  in  1  write data valid.
- app_wdf_end  in  1  last beat of the write burst.
- app_wdf_rdy  out  1  write data accept.
- app_rd_data  out  UI_WIDTH  read data.
- app_rd_data_valid  out  1  read data valid.
- app_rd_data_end  out  1  last beat of the read burst.
- init_calib_complete  out  1  interface usable.
- err_flag  out  1  sticky protocol error.

Behaviour:
- Reset values: all outputs 0; queues empty; read pipeline empty; calibration counter cleared.
  - The backing array is not cleared and keeps its contents across reset.
  - Reset asserted mid-operation flushes queued commands, queued write data and in-flight reads. No partial write is committed. Calibration restarts.
- Calibration: counter increments after rst_n deasserts. init_calib_complete goes to 1 on the cycle the count reaches CALIB_CYCLES and stays there until reset.
  - Before calibration completes, app_rdy and app_wdf_rdy are held at 0.
- Command channel:
  - app_rdy = calibrated AND cmd_count < CMD_DEPTH AND NOT stall_cycle. It is computed from registered state only, so a pop in the same cycle does not free space.
  - A command is accepted when app_en and app_rdy are both 1. {app_cmd, word index} is pushed, where word index = app_addr[MEM_AW+2:3]. Upper address bits wrap modulo the array size.
  - Any app_cmd other than 000 or 001 is accepted, discarded and sets err_flag.
- Write-data channel:
  - app_wdf_rdy = calibrated AND wdf_count < WDF_DEPTH.
  - A beat is accepted when app_wdf_wren and app_wdf_rdy are both 1; {data, mask} is pushed.
  - Each burst is a single beat (4:1 mode). An accepted beat with app_wdf_end = 0 sets err_flag but is still pushed.
  - Data may arrive before, with, or after its command.
- Execution: in order, at most one command per cycle, taken from the command-queue head.
  - WRITE: executes only when wdf is non-empty. It pops both queues and writes every byte whose mask bit is 0. A write at the head with empty wdf stalls later commands, including reads.
  - READ: executes when the queue is non-empty. The array is read on that cycle, so a read queued behind a write returns the new data.
  - RD_LATENCY cycles after execution, app_rd_data_valid = app_rd_data_end = 1 for exactly one cycle. Read data is returned in command order.
- Read back-pressure: none; the master must always sink read data. The pipeline holds up to RD_LATENCY reads in flight, one per cycle.
- Throughput: one command accept and one wdf accept per cycle when no stall applies. Sustained back-to-back reads give back-to-back valids.
- Stall generator: a free-running counter, modulo STALL_PERIOD, starts after calibration. stall_cycle = 1 when the counter equals STALL_PERIOD-1.
- err_flag clears only on reset.

Test Plan:
- Reset release with CALIB_CYCLES=64 -> init_calib_complete rises on cycle 64. app_rdy and app_wdf_rdy are 0 before that and 1 after.
- Write addr 0x40 with data = {16{32'hDEADBEEF}} and mask 0, then read 0x40 -> the read returns DEADBEEF pattern with valid = end = 1, exactly 4 cycles after the read executes.
- Masked write, mask = 64'hFFFF_FFFF_FFFF_FFFE, data = all 0xAA, over prior zeros; then read -> byte 0 = 0xAA, all other bytes 0x00.
- Write command issued 3 cycles before its data, with a read of the same address queued behind it -> the read executes only after the data arrives and returns the new data; the read is not reordered ahead of the write.
- Push 5 commands without supplying write data, CMD_DEPTH=4 -> app_rdy drops after the 4th accept. Supplying data drains the queue and app_rdy returns.
- app_cmd = 3'b010, or a wdf beat with end = 0 -> err_flag = 1 and stays 1. Asserting rst_n low mid-burst clears err_flag, drops app_rd_data_valid immediately, and earlier-written array data still reads back after recalibration.
